// File: rtl/mem_responder.sv
// mem_responder: beat-addressed memory model that takes byte-masked writes and answers
// reads with a 4-beat line after LATENCY cycles. Define MEM_RESPONDER_STALL_EN for LFSR burst gaps.
module mem_responder #(
  parameter int ADDR_BITS  = 28,
  parameter int DATA_BITS  = 128,
  parameter int DEPTH_BITS = 10,
  parameter int LATENCY    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req_valid,
  output logic                   mem_req_ready,
  input  logic [ADDR_BITS-1:0]   mem_req_addr,
  input  logic                   mem_req_rw,
  input  logic                   mem_req_data_valid,
  output logic                   mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                   mem_resp_valid,
  output logic [DATA_BITS-1:0]   mem_resp_data
);

  localparam int         MASK_BITS = DATA_BITS / 8;
  localparam int         ENTRIES   = 1 << DEPTH_BITS;
  localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t                state, state_nxt;
  logic [3:0]            wait_cnt, wait_cnt_nxt;
  logic [1:0]            beat_cnt, beat_cnt_nxt;
  logic [ADDR_BITS-1:0]  line_addr, line_addr_nxt;
  logic                  ready_nxt;
  logic                  resp_valid_nxt;
  logic [DATA_BITS-1:0]  resp_data_nxt;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  stall;
  logic [DEPTH_BITS-1:0] wr_index;
  logic [DEPTH_BITS-1:0] rd_index;
  logic                  unused_bits;

  logic [DATA_BITS-1:0]  storage [0:ENTRIES-1];

  assign mem_req_data_ready = mem_req_ready;
  assign wr_fire  = mem_req_ready && mem_req_valid && mem_req_rw && mem_req_data_valid;
  assign rd_fire  = mem_req_ready && mem_req_valid && !mem_req_rw;
  assign wr_index = mem_req_addr[DEPTH_BITS-1:0];
  assign rd_index = {line_addr[DEPTH_BITS-1:2], beat_cnt};

  // Address bits above the storage depth alias; the line offset is always zero.
  assign unused_bits = ^{mem_req_addr[ADDR_BITS-1:DEPTH_BITS],
                         line_addr[ADDR_BITS-1:DEPTH_BITS], line_addr[1:0]};

`ifdef MEM_RESPONDER_STALL_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign stall   = lfsr[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr_fb, lfsr[15:1]};
  end
`else
  assign stall = 1'b0;
`endif

  // Storage is never reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < MASK_BITS; i++) begin
        if (mem_req_data_mask[i]) storage[wr_index][i*8 +: 8] <= mem_req_data_bits[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      beat_cnt       <= '0;
      line_addr      <= '0;
      mem_req_ready  <= 1'b0;
      mem_resp_valid <= 1'b0;
      mem_resp_data  <= '0;
    end else begin
      state          <= state_nxt;
      wait_cnt       <= wait_cnt_nxt;
      beat_cnt       <= beat_cnt_nxt;
      line_addr      <= line_addr_nxt;
      mem_req_ready  <= ready_nxt;
      mem_resp_valid <= resp_valid_nxt;
      mem_resp_data  <= resp_data_nxt;
    end
  end

  // Ready is registered, so it rises one cycle after the burst's last beat.
  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    beat_cnt_nxt   = beat_cnt;
    line_addr_nxt  = line_addr;
    ready_nxt      = 1'b0;
    resp_valid_nxt = 1'b0;
    resp_data_nxt  = mem_resp_data;
    case (state)
      IDLE: begin
        ready_nxt = !rd_fire;
        if (rd_fire) begin
          line_addr_nxt = {mem_req_addr[ADDR_BITS-1:2], 2'b00};
          beat_cnt_nxt  = 2'd0;
          if (LATENCY == 1) begin
            state_nxt = BURST;
          end else begin
            state_nxt    = WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (wait_cnt <= 4'd1) begin
          state_nxt    = BURST;
          wait_cnt_nxt = 4'd0;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      BURST: begin
        if (!stall) begin
          resp_valid_nxt = 1'b1;
          resp_data_nxt  = storage[rd_index];
          beat_cnt_nxt   = beat_cnt + 2'd1;
          if (beat_cnt == 2'd3) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table vectors, directed corner sequences and random traffic against a
// line-level memory model; honours MEM_RESPONDER_STALL_EN when the design is built with it.
module tb_mem_responder;

  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_req_valid = 1'b0;
  logic         mem_req_ready;
  logic [27:0]  mem_req_addr = '0;
  logic         mem_req_rw = 1'b0;
  logic         mem_req_data_valid = 1'b0;
  logic         mem_req_data_ready;
  logic [127:0] mem_req_data_bits = '0;
  logic [15:0]  mem_req_data_mask = '0;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  mem_responder #(.ADDR_BITS(28), .DATA_BITS(128), .DEPTH_BITS(10), .LATENCY(L)) dut (
    .clk(clk), .reset(rst_n),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [127:0] ref_mem [0:1023];

`ifdef MEM_RESPONDER_STALL_EN
  int edge_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end
`endif

  // Stall decision in force at the most recent rising edge.
  function automatic bit stall_now();
`ifdef MEM_RESPONDER_STALL_EN
    logic [15:0] s;
    s = 16'hACE1;
    for (int i = 1; i < edge_cnt; i++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    return s[0];
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_write(input logic [27:0] addr, input logic [127:0] data, input logic [15:0] mask);
    for (int b = 0; b < 16; b++)
      if (mask[b]) ref_mem[addr[9:0]][b*8 +: 8] = data[b*8 +: 8];
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_write(input logic [27:0] addr, input logic [127:0] data, input logic [15:0] mask);
    chk("wr_ready", mem_req_ready, 1'b1);
    mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_data_valid = 1'b1;
    mem_req_addr = addr; mem_req_data_bits = data; mem_req_data_mask = mask;
    @(posedge clk);
    model_write(addr, data, mask);
    @(negedge clk);
    mem_req_valid = 1'b0; mem_req_data_valid = 1'b0;
  endtask

  task automatic check_burst(input logic [27:0] addr, input bit hold, output logic [127:0] first);
    int beats;
    bit finished;
    int line;
    bit exp_v;
    beats = 0; finished = 0; first = '0;
    line = int'(addr[9:0]) & ~3;
    @(posedge clk);
    for (int k = 0; k <= 64; k++) begin
      @(negedge clk);
      if (k == 0 && !hold) mem_req_valid = 1'b0;
      if (finished) begin
        chk("rd_ready_back", mem_req_ready, 1'b1);
        chk("rd_idle_valid", mem_resp_valid, 1'b0);
        return;
      end
      chk("rd_ready_busy", mem_req_ready, 1'b0);
      exp_v = (k >= L) && !stall_now();
      chk("rd_valid", mem_resp_valid, exp_v);
      if (exp_v) begin
        chk("rd_beat", mem_resp_data, ref_mem[line + beats]);
        if (beats == 0) first = mem_resp_data;
        beats++;
        if (beats == 4) finished = 1;
      end
    end
    chk("rd_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_read(input logic [27:0] addr, input bit hold, output logic [127:0] first);
    chk("rd_accept_ready", mem_req_ready, 1'b1);
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = addr;
    check_burst(addr, hold, first);
  endtask

  typedef struct {
    bit           rw;
    logic [27:0]  addr;
    logic [127:0] data;
    logic [15:0]  mask;
    logic [127:0] first;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [127:0] first;
    logic [127:0] old_v, new_v;
    int vcount;

    vecs[0] = '{1'b1, 28'h0000010, 128'h0123456789ABCDEF0123456789ABCDEF, 16'hFFFF, '0};
    vecs[1] = '{1'b0, 28'h0000012, '0, '0, 128'h0123456789ABCDEF0123456789ABCDEF};
    vecs[2] = '{1'b1, 28'h0000020, 128'h0, 16'hFFFF, '0};
    vecs[3] = '{1'b1, 28'h0000020, 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5FF, 16'h0001, '0};
    vecs[4] = '{1'b0, 28'h0000021, '0, '0, 128'h000000000000000000000000000000FF};
    vecs[5] = '{1'b1, 28'h4000024, 128'hDEADBEEF00112233445566778899AABB, 16'hFFFF, '0};
    vecs[6] = '{1'b0, 28'h0000024, '0, '0, 128'hDEADBEEF00112233445566778899AABB};

    // Reset state, then ready rises on the first edge after release.
    repeat (2) @(negedge clk);
    chk("rst_ready", mem_req_ready, 1'b0);
    chk("rst_data_ready", mem_req_data_ready, 1'b0);
    chk("rst_valid", mem_resp_valid, 1'b0);
    chk("rst_data", mem_resp_data, '0);
    rst_n = 1'b1;
    #1 chk("rel_ready_pre_edge", mem_req_ready, 1'b0);
    @(negedge clk);
    chk("rel_ready", mem_req_ready, 1'b1);
    chk("rel_data_ready", mem_req_data_ready, 1'b1);

    for (int i = 0; i < 64; i++)
      do_write(28'(i), {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rw) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].mask);
      end else begin
        do_read(vecs[i].addr, 1'b0, first);
        chk($sformatf("vec%0d_first", i), first, vecs[i].first);
      end
    end

    // Write request without data must stall without touching storage.
    old_v = ref_mem[10'h30];
    new_v = {$urandom, $urandom, $urandom, $urandom};
    mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_data_valid = 1'b0;
    mem_req_addr = 28'h0000030; mem_req_data_mask = 16'hFFFF;
    mem_req_data_bits = ~new_v;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("nodata_ready", mem_req_ready, 1'b1);
    end
    mem_req_data_valid = 1'b1; mem_req_data_mask = 16'h00FF; mem_req_data_bits = new_v;
    @(posedge clk);
    model_write(28'h0000030, new_v, 16'h00FF);
    @(negedge clk);
    mem_req_valid = 1'b0; mem_req_data_valid = 1'b0;
    do_read(28'h0000031, 1'b0, first);
    chk("nodata_merge", first, {old_v[127:64], new_v[63:0]});

    // Request valid held high through a burst; the next read is taken when ready returns.
    do_read(28'h0000022, 1'b1, first);
    mem_req_addr = 28'h0000027;
    check_burst(28'h0000027, 1'b0, first);
    chk("b2b_second_first", first, 128'hDEADBEEF00112233445566778899AABB);

    // Reset during the second beat aborts the burst.
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 28'h0000010;
    @(posedge clk);
    @(negedge clk);
    mem_req_valid = 1'b0;
    vcount = 0;
    for (int k = 0; k < 64 && vcount < 2; k++) begin
      @(negedge clk);
      if (mem_resp_valid) vcount++;
    end
    chk("abort_reached_beat2", 32'(vcount), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", mem_resp_valid, 1'b0);
    chk("abort_data", mem_resp_data, '0);
    chk("abort_ready", mem_req_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_back", mem_req_ready, 1'b1);
    vcount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_resp_valid) vcount++;
    end
    chk("abort_no_more_beats", 32'(vcount), 32'd0);

    do_read(28'h0000013, 1'b0, first);
    chk("storage_kept", first, 128'h0123456789ABCDEF0123456789ABCDEF);

    // Random traffic inside the preloaded region with aliased upper address bits.
    for (int i = 0; i < 40; i++) begin
      logic [27:0] a;
      a = {18'($urandom_range(0, (1 << 18) - 1)), 4'b0000, 6'($urandom_range(0, 63))};
      if ($urandom_range(0, 1) == 1)
        do_write(a, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom_range(0, 65535)));
      else
        do_read(a, 1'b0, first);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
